// File: rtl/free_list.sv
// Physical-register free list: circular FIFO of free tags fed by ROB retire and drained by
// rename, with a single head-pointer checkpoint for rollback on branch mispredict.
module free_list #(
    parameter int unsigned NUM_PREGS = 128,
    parameter int unsigned NUM_ARCH  = 32,
    parameter int unsigned PREG_W    = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alloc_req,
    output logic [PREG_W-1:0] alloc_preg,
    output logic              alloc_valid,
    input  logic              write_en,
    input  logic [PREG_W-1:0] rob_data_in,
    input  logic              checkpoint_save,
    input  logic              mispredict,
    output logic [PREG_W:0]   free_count,
    output logic              overflow
);

    localparam int unsigned PTR_W = PREG_W + 1;
    localparam int unsigned NUM_FREE_INIT = NUM_PREGS - NUM_ARCH;
    localparam logic [PTR_W-1:0] INIT_TAIL  = PTR_W'(NUM_FREE_INIT);
    localparam logic [PTR_W-1:0] FULL_COUNT = PTR_W'(NUM_PREGS);

    logic [PREG_W-1:0] mem_q [NUM_PREGS];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W-1:0] saved_head_q, saved_head_d;
    logic [PTR_W-1:0] head_after_pop;
    logic             overflow_q, overflow_d;

    logic do_pop;
    logic push_req;
    logic do_push;
    logic full;

    always_comb begin
        free_count  = tail_q - head_q;
        alloc_valid = (free_count != '0);
        alloc_preg  = mem_q[head_q[PREG_W-1:0]];
        overflow    = overflow_q;
    end

    always_comb begin
        full     = (free_count == FULL_COUNT);
        do_pop   = alloc_req && alloc_valid && !mispredict;
        push_req = write_en && (rob_data_in != '0);
        do_push  = push_req && !full;

        head_after_pop = do_pop ? head_q + PTR_W'(1) : head_q;

        // Rollback wins over any same-cycle pop; a retiring push is older than the branch.
        head_d       = mispredict ? saved_head_q : head_after_pop;
        saved_head_d = (checkpoint_save && !mispredict) ? head_after_pop : saved_head_q;
        tail_d       = do_push ? tail_q + PTR_W'(1) : tail_q;
        overflow_d   = overflow_q || (push_req && full);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q       <= '0;
            tail_q       <= INIT_TAIL;
            saved_head_q <= '0;
            overflow_q   <= 1'b0;
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            saved_head_q <= saved_head_d;
            overflow_q   <= overflow_d;
        end
    end

    // Architectural tags p0..p(NUM_ARCH-1) are mapped at reset, so only the rest start free.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_PREGS; i++) begin
                mem_q[i] <= (i < NUM_FREE_INIT) ? PREG_W'(NUM_ARCH + i) : '0;
            end
        end else if (do_push) begin
            mem_q[tail_q[PREG_W-1:0]] <= rob_data_in;
        end
    end

endmodule

// File: tb/tb_free_list.sv
// Self-checking bench for free_list: directed scenarios plus randomized traffic compared
// against a queue-based model of the free set and the speculative pops since the checkpoint.
module tb_free_list;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       alloc_req = 1'b0;
    logic [6:0] alloc_preg;
    logic       alloc_valid;
    logic       write_en = 1'b0;
    logic [6:0] rob_data_in = '0;
    logic       checkpoint_save = 1'b0;
    logic       mispredict = 1'b0;
    logic [7:0] free_count;
    logic       overflow;

    int errors = 0;
    int checks = 0;

    // Model: free tags in allocation order, and tags handed out since the last checkpoint.
    int free_q[$];
    int spec_q[$];
    bit ovf_m;

    free_list #(.NUM_PREGS(128), .NUM_ARCH(32), .PREG_W(7)) dut (
        .clk            (clk),
        .reset          (reset),
        .alloc_req      (alloc_req),
        .alloc_preg     (alloc_preg),
        .alloc_valid    (alloc_valid),
        .write_en       (write_en),
        .rob_data_in    (rob_data_in),
        .checkpoint_save(checkpoint_save),
        .mispredict     (mispredict),
        .free_count     (free_count),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        free_q.delete();
        spec_q.delete();
        for (int i = 32; i < 128; i++) free_q.push_back(i);
        ovf_m = 1'b0;
    endtask

    // Apply one cycle of stimulus to both the model and the DUT; returns 1 ns after the edge.
    task automatic step(input bit req, input bit we, input int data, input bit ck, input bit mp);
        bit was_full;
        was_full = (free_q.size() == 128);
        if (req && free_q.size() > 0 && !mp) spec_q.push_back(free_q.pop_front());
        if (mp) begin
            for (int i = spec_q.size() - 1; i >= 0; i--) free_q.push_front(spec_q[i]);
            spec_q.delete();
        end
        if (we && data != 0) begin
            if (was_full) ovf_m = 1'b1;
            else free_q.push_back(data);
        end
        if (ck && !mp) spec_q.delete();
        alloc_req       = req;
        write_en        = we;
        rob_data_in     = 7'(data);
        checkpoint_save = ck;
        mispredict      = mp;
        @(posedge clk);
        #1;
        alloc_req       = 1'b0;
        write_en        = 1'b0;
        rob_data_in     = '0;
        checkpoint_save = 1'b0;
        mispredict      = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        #2;
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (alloc_valid !== 1'b1) begin errors++;
            $display("FAIL reset_valid: got %b expected 1", alloc_valid); end
        checks++; if (alloc_preg !== 7'd32) begin errors++;
            $display("FAIL reset_preg: got %0d expected 32", alloc_preg); end
        checks++; if (free_count !== 8'd96) begin errors++;
            $display("FAIL reset_count: got %0d expected 96", free_count); end
        checks++; if (overflow !== 1'b0) begin errors++;
            $display("FAIL reset_overflow: got %b expected 0", overflow); end
    endtask

    task automatic test_drain_and_refill();
        int bad = 0;
        apply_reset();
        for (int i = 0; i < 96; i++) begin
            if (alloc_preg !== 7'(32 + i) || alloc_valid !== 1'b1) bad++;
            step(1, 0, 0, 0, 0);
        end
        checks++; if (bad != 0) begin errors++;
            $display("FAIL drain_order: got %0d wrong tags expected 0", bad); end
        checks++; if (alloc_valid !== 1'b0 || free_count !== 8'd0) begin errors++;
            $display("FAIL drain_empty: got valid=%b count=%0d expected 0/0", alloc_valid, free_count); end
        step(1, 0, 0, 0, 0);
        checks++; if (free_count !== 8'd0 || alloc_valid !== 1'b0) begin errors++;
            $display("FAIL pop_when_empty: got count=%0d expected 0", free_count); end
        step(0, 1, 45, 0, 0);
        checks++; if (alloc_valid !== 1'b1 || alloc_preg !== 7'd45 || free_count !== 8'd1) begin
            errors++;
            $display("FAIL push_45: got valid=%b preg=%0d count=%0d expected 1/45/1",
                     alloc_valid, alloc_preg, free_count); end
        step(0, 1, 0, 0, 0);
        checks++; if (free_count !== 8'd1 || alloc_preg !== 7'd45) begin errors++;
            $display("FAIL push_p0: got count=%0d preg=%0d expected 1/45", free_count, alloc_preg); end
        step(1, 1, 50, 0, 0);
        checks++; if (free_count !== 8'd1 || alloc_preg !== 7'd50) begin errors++;
            $display("FAIL pop_push: got count=%0d preg=%0d expected 1/50", free_count, alloc_preg); end
        step(1, 0, 0, 0, 0);
        step(1, 1, 60, 0, 0);
        checks++; if (free_count !== 8'd1 || alloc_preg !== 7'd60) begin errors++;
            $display("FAIL no_bypass: got count=%0d preg=%0d expected 1/60", free_count, alloc_preg); end
    endtask

    task automatic test_rollback();
        apply_reset();
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
        step(1, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        checks++; if (alloc_preg !== 7'd38 || free_count !== 8'd90) begin errors++;
            $display("FAIL pre_rollback: got preg=%0d count=%0d expected 38/90", alloc_preg, free_count); end
        step(0, 0, 0, 0, 1);
        checks++; if (alloc_preg !== 7'd36 || free_count !== 8'd92) begin errors++;
            $display("FAIL rollback: got preg=%0d count=%0d expected 36/92", alloc_preg, free_count); end
        step(1, 0, 0, 0, 0);
        step(1, 1, 40, 1, 1);
        checks++; if (alloc_preg !== 7'd36 || free_count !== 8'd93) begin errors++;
            $display("FAIL rollback_push: got preg=%0d count=%0d expected 36/93", alloc_preg, free_count); end
    endtask

    task automatic test_wrap_overflow();
        int bad = 0;
        int exp;
        apply_reset();
        for (int i = 0; i < 200; i++) begin
            exp = free_q[0];
            if (alloc_preg !== 7'(exp) || free_count !== 8'd96) bad++;
            step(1, 1, exp, 0, 0);
        end
        checks++; if (bad != 0) begin errors++;
            $display("FAIL wrap_order: got %0d bad cycles expected 0", bad); end
        checks++; if (alloc_preg !== 7'(free_q[0])) begin errors++;
            $display("FAIL wrap_head: got %0d expected %0d", alloc_preg, free_q[0]); end
        for (int i = 0; i < 32; i++) step(0, 1, 1 + i, 0, 0);
        checks++; if (free_count !== 8'd128 || overflow !== 1'b0) begin errors++;
            $display("FAIL fill: got count=%0d ovf=%b expected 128/0", free_count, overflow); end
        for (int i = 0; i < 33; i++) step(0, 1, 90, 0, 0);
        checks++; if (free_count !== 8'd128 || overflow !== 1'b1) begin errors++;
            $display("FAIL overflow: got count=%0d ovf=%b expected 128/1", free_count, overflow); end
        step(1, 0, 0, 0, 0);
        step(0, 1, 7, 0, 0);
        checks++; if (overflow !== 1'b1 || free_count !== 8'd128) begin errors++;
            $display("FAIL overflow_sticky: got ovf=%b count=%0d expected 1/128", overflow, free_count); end
        // Draining the full ring exercises the final-slot wrap and order of refill tags.
        bad = 0;
        for (int i = 0; i < 128; i++) begin
            if (alloc_preg !== 7'(free_q[0])) bad++;
            step(1, 0, 0, 0, 0);
        end
        checks++; if (bad != 0 || free_count !== 8'd0) begin errors++;
            $display("FAIL full_drain: got %0d bad tags count=%0d expected 0/0", bad, free_count); end
    endtask

    task automatic test_random();
        int bad = 0;
        bit req, we, ck, mp;
        int data;
        apply_reset();
        for (int i = 0; i < 600; i++) begin
            if (alloc_valid !== (free_q.size() != 0) || free_count !== 8'(free_q.size())
                || overflow !== ovf_m) bad++;
            else if (free_q.size() != 0 && alloc_preg !== 7'(free_q[0])) bad++;
            req  = ($urandom_range(0, 3) != 0);
            we   = ($urandom_range(0, 2) != 0) && (free_q.size() + spec_q.size() < 128);
            data = (we && $urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 127));
            ck   = ($urandom_range(0, 3) == 0);
            mp   = ($urandom_range(0, 9) == 0);
            step(req, we, data, ck, mp);
        end
        checks++; if (bad != 0) begin errors++;
            $display("FAIL random_traffic: got %0d mismatched cycles expected 0", bad); end
        checks++; if (free_count !== 8'(free_q.size())) begin errors++;
            $display("FAIL random_final: got count=%0d expected %0d", free_count, free_q.size()); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        checks++; if (alloc_preg !== 7'd32 || free_count !== 8'd96 || alloc_valid !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: got preg=%0d count=%0d expected 32/96", alloc_preg, free_count); end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_drain_and_refill();
        test_rollback();
        test_wrap_overflow();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
